sort_dmem: RTL and testbench

- Parametrised data memory for the single-cycle sorting core, replacing the fixed 256x32 data RAM.
- CPU port: synchronous write, asynchronous read, word-addressed.
- Built-in bubble-sort engine sorts a programmable window of the memory in place.
  - Supports ascending/descending order, signed/unsigned compare, and early exit on a swap-free pass.
- While the engine runs, the core polls `sort_busy`/`sort_done` instead of executing the software sort loop.

---
 rtl/sort_dmem_if.sv | 33 +++
 rtl/sort_dmem.sv | 135 +++++++++++++
 tb/tb_sort_dmem.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sort_dmem_if.sv
// CPU-side bus of the sorting data memory: word access plus sort control.
// master = CPU (drives requests), slave = memory (drives data and status).
interface sort_dmem_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic              memwrite;
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  write_data;
    logic [WIDTH-1:0]  read_data;
    logic              sort_start;
    logic [ADDR_W-1:0] sort_base;
    logic [ADDR_W:0]   sort_len;
    logic              sort_desc;
    logic              sort_signed;
    logic              sort_busy;
    logic              sort_done;
    logic [CNT_W-1:0]  sort_passes;
    logic [CNT_W-1:0]  sort_swaps;

    modport master (
        output memwrite, address, write_data,
        output sort_start, sort_base, sort_len, sort_desc, sort_signed,
        input  read_data, sort_busy, sort_done, sort_passes, sort_swaps
    );

    modport slave (
        input  memwrite, address, write_data,
        input  sort_start, sort_base, sort_len, sort_desc, sort_signed,
        output read_data, sort_busy, sort_done, sort_passes, sort_swaps
    );
endinterface

// File: rtl/sort_dmem.sv
// Word-addressed data memory with an in-place bubble-sort engine.
// Ports: clk, rst (async active-low), bus (sort_dmem_if.slave).
module sort_dmem #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    sort_dmem_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   L_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   L_DEP = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        PASS_END,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] base, j, idx_a, idx_b;
    logic [ADDR_W:0]   limit, room, eff_len;
    logic              desc, sgn, swapped;
    logic [CNT_W-1:0]  passes, swaps;
    logic [WIDTH-1:0]  op_a, op_b, key_a, key_b;
    logic              ooo, last;

    // Window is clamped so it never runs past the top word.
    assign room    = L_DEP - {1'b0, bus.sort_base};
    assign eff_len = (bus.sort_len < room) ? bus.sort_len : room;

    assign idx_a = base + j;
    assign idx_b = idx_a + A_ONE;
    assign op_a  = mem[idx_a];
    assign op_b  = mem[idx_b];

    // Flipping the sign bit turns a two's-complement compare into unsigned.
    assign key_a = {op_a[WIDTH-1] ^ sgn, op_a[WIDTH-2:0]};
    assign key_b = {op_b[WIDTH-1] ^ sgn, op_b[WIDTH-2:0]};
    assign ooo   = desc ? (key_a < key_b) : (key_a > key_b);
    assign last  = ({1'b0, j} == limit - L_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.sort_start)
                    state_nx = (eff_len <= L_ONE) ? DONE : COMPARE;
            end
            COMPARE: begin
                if (last) state_nx = PASS_END;
            end
            PASS_END: begin
                if (!swapped || limit == L_ONE) state_nx = DONE;
                else                            state_nx = COMPARE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base    <= '0;
            desc    <= 1'b0;
            sgn     <= 1'b0;
            limit   <= '0;
            j       <= '0;
            swapped <= 1'b0;
            passes  <= '0;
            swaps   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.sort_start) begin
                        base    <= bus.sort_base;
                        desc    <= bus.sort_desc;
                        sgn     <= bus.sort_signed;
                        limit   <= eff_len - L_ONE;
                        j       <= '0;
                        swapped <= 1'b0;
                        passes  <= '0;
                        swaps   <= '0;
                    end
                end
                COMPARE: begin
                    if (ooo) begin
                        swapped <= 1'b1;
                        if (swaps != '1) swaps <= swaps + C_ONE;
                    end
                    if (!last) j <= j + A_ONE;
                end
                PASS_END: begin
                    passes <= passes + C_ONE;
                    if (swapped && limit != L_ONE) begin
                        limit   <= limit - L_ONE;
                        j       <= '0;
                        swapped <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The engine owns the array while busy; CPU writes are dropped then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == COMPARE && ooo) begin
            mem[idx_a] <= op_b;
            mem[idx_b] <= op_a;
        end else if (bus.memwrite && (state == IDLE || state == DONE)) begin
            mem[bus.address] <= bus.write_data;
        end
    end

    assign bus.read_data   = mem[bus.address];
    assign bus.sort_busy   = (state == COMPARE) || (state == PASS_END);
    assign bus.sort_done   = (state == DONE);
    assign bus.sort_passes = passes;
    assign bus.sort_swaps  = swaps;
endmodule

// File: tb/tb_sort_dmem.sv
// Randomised bench for sort_dmem against a rank/inversion-count reference.
// Drives the bus through sort_dmem_if; checks data, counters and latency.
module tb_sort_dmem;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sort_dmem_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    sort_dmem #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] model [DEPTH];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input int addr, output logic [WIDTH-1:0] d);
        bus.address = ADDR_W'(addr);
        #1;
        d = bus.read_data;
    endtask

    task automatic wr(input int addr, input logic [WIDTH-1:0] d);
        @(negedge clk);
        bus.memwrite   = 1'b1;
        bus.address    = ADDR_W'(addr);
        bus.write_data = d;
        @(negedge clk);
        bus.memwrite = 1'b0;
        model[addr]  = d;
    endtask

    // True when a must be placed after b in the requested order.
    function automatic bit after(input logic [WIDTH-1:0] a, b,
                                 input bit desc, sgn);
        if (sgn) return desc ? ($signed(a) < $signed(b))
                             : ($signed(a) > $signed(b));
        return desc ? (a < b) : (a > b);
    endfunction

    // Sorts the model window (stable) and derives passes/swaps/latency
    // from inversion counts: bubble sort needs max-left-inversions passes
    // with swaps, plus one clean pass, capped at n-1.
    task automatic predict(input int base, len, input bit desc, sgn,
                           output int n, passes, swaps, lat);
        logic [WIDTH-1:0] q [DEPTH];
        logic [WIDTH-1:0] r [DEPTH];
        int inv, mx, pos;
        n = (len < DEPTH - base) ? len : DEPTH - base;
        for (int i = 0; i < n; i++) q[i] = model[base + i];
        swaps = 0;
        mx = 0;
        for (int i = 0; i < n; i++) begin
            inv = 0;
            pos = 0;
            for (int k = 0; k < n; k++) begin
                if (k < i && after(q[k], q[i], desc, sgn)) inv++;
                if (after(q[i], q[k], desc, sgn)) pos++;
                else if (k < i && q[k] == q[i]) pos++;
            end
            r[pos] = q[i];
            swaps += inv;
            if (inv > mx) mx = inv;
        end
        for (int i = 0; i < n; i++) model[base + i] = r[i];
        if (swaps > 65535) swaps = 65535;
        if (n <= 1) begin
            passes = 0;
            lat = 1;
        end else begin
            passes = (mx + 1 < n - 1) ? mx + 1 : n - 1;
            lat = 1;
            for (int p = 0; p < passes; p++) lat += n - p;
        end
    endtask

    task automatic run_sort(input string tag, input int base, len,
                            input bit desc, sgn, input bit meddle);
        int n, passes, swaps, lat, cyc;
        logic [WIDTH-1:0] d;
        predict(base, len, desc, sgn, n, passes, swaps, lat);
        @(negedge clk);
        bus.sort_start  = 1'b1;
        bus.sort_base   = ADDR_W'(base);
        bus.sort_len    = (ADDR_W + 1)'(len);
        bus.sort_desc   = desc;
        bus.sort_signed = sgn;
        @(negedge clk);
        bus.sort_start = 1'b0;
        cyc = 1;
        if (n > 1) check({tag, "_busy"}, bus.sort_busy, 1);
        while (!bus.sort_done && cyc < 5000) begin
            if (meddle && cyc == 3) begin
                bus.memwrite    = 1'b1;
                bus.address     = ADDR_W'(base + 1);
                bus.write_data  = 32'hDEAD_BEEF;
                bus.sort_start  = 1'b1;
                bus.sort_base   = '0;
                bus.sort_len    = 9'd2;
            end else begin
                bus.memwrite   = 1'b0;
                bus.sort_start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.memwrite   = 1'b0;
        bus.sort_start = 1'b0;
        check({tag, "_lat"}, cyc, lat);
        check({tag, "_passes"}, bus.sort_passes, passes);
        check({tag, "_swaps"}, bus.sort_swaps, swaps);
        @(negedge clk);
        check({tag, "_done_once"}, bus.sort_done, 0);
        check({tag, "_busy_after"}, bus.sort_busy, 0);
        for (int a = base - 1; a <= base + n; a++) begin
            if (a >= 0 && a < DEPTH) begin
                rd(a, d);
                check($sformatf("%s_m%0d", tag, a), d, model[a]);
            end
        end
        rd(0, d);
        check({tag, "_m0"}, d, model[0]);
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        int bs, ln;
        bus.memwrite    = 1'b1;
        bus.address     = 8'd3;
        bus.write_data  = 32'h55;
        bus.sort_start  = 1'b0;
        bus.sort_base   = '0;
        bus.sort_len    = '0;
        bus.sort_desc   = 1'b0;
        bus.sort_signed = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        bus.memwrite = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd(3, d);
        check("rst_mem3", d, 0);
        check("rst_busy", bus.sort_busy, 0);
        check("rst_done", bus.sort_done, 0);
        check("rst_passes", bus.sort_passes, 0);
        check("rst_swaps", bus.sort_swaps, 0);

        wr(0, 42949672); wr(1, 98374839); wr(2, 23784932);
        wr(3, 74839201); wr(4, 12938475); wr(5, 32'h777);
        run_sort("asc", 0, 5, 0, 0, 0);
        rd(0, d); check("asc_first", d, 12938475);
        rd(4, d); check("asc_last", d, 98374839);

        wr(9, 32'hAAAA); wr(14, 32'hBBBB);
        wr(10, -5); wr(11, 3); wr(12, 0); wr(13, -1);
        run_sort("desc_s", 10, 4, 1, 1, 0);
        rd(10, d); check("desc_s_first", d, 3);
        rd(13, d); check("desc_s_last", d, 32'hFFFF_FFFB);

        wr(30, 1); wr(31, 2); wr(32, 3); wr(33, 4);
        run_sort("early", 30, 4, 0, 0, 0);
        check("early_passes", bus.sort_passes, 1);

        wr(20, 32'h99);
        run_sort("len1", 20, 1, 0, 0, 0);
        check("len1_passes", bus.sort_passes, 0);

        wr(0, 32'h1234); wr(254, 9); wr(255, 2);
        run_sort("clamp", 254, 10, 0, 0, 0);
        rd(254, d); check("clamp_254", d, 2);

        for (int i = 0; i < 8; i++) wr(40 + i, 8 - i);
        run_sort("meddle", 40, 8, 0, 0, 1);

        for (int it = 0; it < 25; it++) begin
            bs = (it % 5 == 4) ? $urandom_range(240, 255) : $urandom_range(0, 250);
            ln = $urandom_range(0, 12);
            for (int i = 0; i < ln && bs + i < DEPTH; i++) begin
                if ($urandom_range(0, 1) == 1)
                    wr(bs + i, $urandom_range(0, 6) - 3);
                else
                    wr(bs + i, $urandom);
            end
            run_sort($sformatf("rnd%0d", it), bs, ln,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        for (int i = 0; i < 6; i++) wr(100 + i, 6 - i);
        @(negedge clk);
        bus.sort_start = 1'b1;
        bus.sort_base  = 8'd100;
        bus.sort_len   = 9'd6;
        bus.sort_desc  = 1'b0;
        @(negedge clk);
        bus.sort_start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_pre", bus.sort_busy, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", bus.sort_busy, 0);
        check("abort_done", bus.sort_done, 0);
        check("abort_swaps", bus.sort_swaps, 0);
        rd(100, d); check("abort_m100", d, 0);
        rd(105, d); check("abort_m105", d, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_idle", bus.sort_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
